// File: rtl/bus_mux_pkg.sv
// Shared constants and types for the CPU datapath bus: widths, source indices, bus word type.
package bus_mux_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_GPR = 16;
  localparam int unsigned NUM_SRC = 24;
  localparam int unsigned SEL_W   = 5;

  localparam int unsigned SRC_R0  = 0;
  localparam int unsigned SRC_R1  = 1;
  localparam int unsigned SRC_R2  = 2;
  localparam int unsigned SRC_R3  = 3;
  localparam int unsigned SRC_R4  = 4;
  localparam int unsigned SRC_R5  = 5;
  localparam int unsigned SRC_R6  = 6;
  localparam int unsigned SRC_R7  = 7;
  localparam int unsigned SRC_R8  = 8;
  localparam int unsigned SRC_R9  = 9;
  localparam int unsigned SRC_R10 = 10;
  localparam int unsigned SRC_R11 = 11;
  localparam int unsigned SRC_R12 = 12;
  localparam int unsigned SRC_R13 = 13;
  localparam int unsigned SRC_R14 = 14;
  localparam int unsigned SRC_R15 = 15;

  localparam int unsigned SRC_HI     = 16;
  localparam int unsigned SRC_LO     = 17;
  localparam int unsigned SRC_ZHIGH  = 18;
  localparam int unsigned SRC_ZLOW   = 19;
  localparam int unsigned SRC_PC     = 20;
  localparam int unsigned SRC_MDR    = 21;
  localparam int unsigned SRC_INPORT = 22;
  localparam int unsigned SRC_CSIGN  = 23;
  localparam int unsigned SRC_NONE   = 31;

  typedef logic [DATA_W-1:0] bus_word_t;

endpackage

// File: rtl/bus_reg.sv
// One general-purpose register: loads d on the rising edge when enabled, synchronous
// active-low clear has priority over the enable.
module bus_reg
  import bus_mux_pkg::*;
(
  input  logic      Clock,
  input  logic      clr,
  input  logic      enable,
  input  bus_word_t d,
  output bus_word_t q
);

  bus_word_t q_q;

  always_ff @(posedge Clock) begin
    if (!clr) begin
      q_q <= '0;
    end else if (enable) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bus_mux.sv
// Central datapath bus: R0-R15 bank plus 8 external sources, one-hot strobes, lowest index wins.
// Optional macro BUS_MUX_SEL_ERR_EN adds the sel_err output flagging multiple strobes.
module bus_mux
  import bus_mux_pkg::*;
(
  input  logic                      Clock,
  input  logic                      clr,
  input  logic [NUM_GPR-1:0]        R_in,
  input  bus_word_t                 HI_data,
  input  bus_word_t                 LO_data,
  input  bus_word_t                 Zhigh_data,
  input  bus_word_t                 Zlow_data,
  input  bus_word_t                 PC_data,
  input  bus_word_t                 MDR_data,
  input  bus_word_t                 InPort_data,
  input  bus_word_t                 C_sign_data,
  input  logic [NUM_SRC-1:0]        out_sel,
  output bus_word_t                 BusMuxout,
  output logic [NUM_GPR*DATA_W-1:0] R_data,
  output logic [SEL_W-1:0]          sel_code
`ifdef BUS_MUX_SEL_ERR_EN
  ,
  output logic                      sel_err
`endif
);

  bus_word_t gpr_q [NUM_GPR];
  bus_word_t src   [NUM_SRC];

  always_comb begin
    for (int g = 0; g < NUM_GPR; g++) begin
      src[g] = gpr_q[g];
    end
    src[SRC_HI]     = HI_data;
    src[SRC_LO]     = LO_data;
    src[SRC_ZHIGH]  = Zhigh_data;
    src[SRC_ZLOW]   = Zlow_data;
    src[SRC_PC]     = PC_data;
    src[SRC_MDR]    = MDR_data;
    src[SRC_INPORT] = InPort_data;
    src[SRC_CSIGN]  = C_sign_data;
  end

  // Scan high to low so the lowest asserted strobe is the last, winning assignment.
  always_comb begin
    sel_code = SEL_W'(SRC_NONE);
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (out_sel[k]) begin
        sel_code = SEL_W'(k);
      end
    end
  end

  always_comb begin
    BusMuxout = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_code == SEL_W'(k)) begin
        BusMuxout = src[k];
      end
    end
  end

  for (genvar g = 0; g < NUM_GPR; g++) begin : g_gpr
    bus_reg u_reg (
      .Clock  (Clock),
      .clr    (clr),
      .enable (R_in[g]),
      .d      (BusMuxout),
      .q      (gpr_q[g])
    );
    assign R_data[g*DATA_W +: DATA_W] = gpr_q[g];
  end

`ifdef BUS_MUX_SEL_ERR_EN
  // Clearing the lowest set bit leaves something only when two or more strobes are active.
  assign sel_err = |(out_sel & (out_sel - NUM_SRC'(1)));

  always_ff @(posedge Clock) begin
    if (clr) begin
      assert (!sel_err)
        else $warning("bus_mux: multiple out_sel strobes asserted (out_sel=%h)", out_sel);
    end
  end
`endif

endmodule

// File: tb/tb_bus_mux.sv
// Directed bench for bus_mux: expectations queued at drive time, popped at each observation.
module tb_bus_mux;
  import bus_mux_pkg::*;

  localparam int unsigned RW = NUM_GPR * DATA_W;

  typedef struct {
    string          tag;
    logic [RW-1:0]  val;
  } exp_t;

  logic                 Clock = 1'b0;
  logic                 clr;
  logic [NUM_GPR-1:0]   R_in;
  bus_word_t            HI_data, LO_data, Zhigh_data, Zlow_data;
  bus_word_t            PC_data, MDR_data, InPort_data, C_sign_data;
  logic [NUM_SRC-1:0]   out_sel;
  bus_word_t            BusMuxout;
  logic [RW-1:0]        R_data;
  logic [SEL_W-1:0]     sel_code;
`ifdef BUS_MUX_SEL_ERR_EN
  logic                 sel_err;
`endif

  exp_t q_exp[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 Clock = ~Clock;

  bus_mux dut (
    .Clock       (Clock),
    .clr         (clr),
    .R_in        (R_in),
    .HI_data     (HI_data),
    .LO_data     (LO_data),
    .Zhigh_data  (Zhigh_data),
    .Zlow_data   (Zlow_data),
    .PC_data     (PC_data),
    .MDR_data    (MDR_data),
    .InPort_data (InPort_data),
    .C_sign_data (C_sign_data),
    .out_sel     (out_sel),
    .BusMuxout   (BusMuxout),
    .R_data      (R_data),
    .sel_code    (sel_code)
`ifdef BUS_MUX_SEL_ERR_EN
    ,
    .sel_err     (sel_err)
`endif
  );

  task automatic push(input string tag, input logic [RW-1:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    q_exp.push_back(e);
  endtask

  task automatic pop_cmp(input logic [RW-1:0] obs);
    exp_t e;
    n_cmp++;
    if (q_exp.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed %h, required an expectation", obs);
    end else begin
      e = q_exp.pop_front();
      assert (obs === e.val)
        else begin
          n_fail++;
          $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
        end
    end
  endtask

  function automatic logic [RW-1:0] reg_word(input int i, input bus_word_t v);
    logic [RW-1:0] r;
    r = '0;
    r[i*DATA_W +: DATA_W] = v;
    return r;
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [NUM_SRC-1:0] strobe(input int k);
    logic [NUM_SRC-1:0] s;
    s = '0;
    s[k] = 1'b1;
    return s;
  endfunction

  initial begin
    HI_data = 32'h110; LO_data = 32'h111; Zhigh_data = 32'h112; Zlow_data = 32'h113;
    PC_data = 32'h114; InPort_data = 32'h116; C_sign_data = 32'h117;

    // Reset dominates loads
    clr = 1'b0; R_in = '1; MDR_data = 32'hDEADBEEF; out_sel = strobe(SRC_MDR);
    step(); step();
    push("reset_rdata", '0);                 pop_cmp(R_data);
    push("reset_bus", RW'(32'hDEADBEEF));    pop_cmp(RW'(BusMuxout));

    // External load MDR -> R2
    clr = 1'b1; R_in = '0; R_in[2] = 1'b1; MDR_data = 32'd34;
    #1;
    push("ext_sel_code", RW'(SRC_MDR));      pop_cmp(RW'(sel_code));
    step();
    R_in = '0;
    push("ext_rdata", reg_word(2, 32'd34));  pop_cmp(R_data);

    // Chain R2 -> R4 -> R5
    out_sel = strobe(2); R_in = '0; R_in[4] = 1'b1; step();
    out_sel = strobe(4); R_in = '0; R_in[5] = 1'b1; step();
    R_in = '0; out_sel = strobe(5); #1;
    push("chain_bus", RW'(32'd34));          pop_cmp(RW'(BusMuxout));
    push("chain_sel", RW'(5));               pop_cmp(RW'(sel_code));
    push("chain_r4", RW'(32'd34));           pop_cmp(RW'(R_data[4*DATA_W +: DATA_W]));
    push("chain_r5", RW'(32'd34));           pop_cmp(RW'(R_data[5*DATA_W +: DATA_W]));

    // Priority between two GPR strobes, then no strobe
    out_sel = strobe(SRC_MDR); MDR_data = 32'd7; R_in = '0; R_in[3] = 1'b1; step();
    MDR_data = 32'd9; R_in = '0; R_in[9] = 1'b1; step();
    R_in = '0; out_sel = strobe(3) | strobe(9); #1;
    push("prio_bus", RW'(32'd7));            pop_cmp(RW'(BusMuxout));
    push("prio_sel", RW'(3));                pop_cmp(RW'(sel_code));
`ifdef BUS_MUX_SEL_ERR_EN
    push("prio_sel_err", RW'(1));            pop_cmp(RW'(sel_err));
`endif
    out_sel = '0; #1;
    push("none_bus", '0);                    pop_cmp(RW'(BusMuxout));
    push("none_sel", RW'(31));               pop_cmp(RW'(sel_code));

    // Every external source in turn
    MDR_data = 32'h115;
    for (int k = SRC_HI; k <= SRC_CSIGN; k++) begin
      out_sel = strobe(k); #1;
      push($sformatf("ext%0d_bus", k), RW'(32'h100 + k)); pop_cmp(RW'(BusMuxout));
      push($sformatf("ext%0d_sel", k), RW'(k));           pop_cmp(RW'(sel_code));
    end

    // Self-load holds; multi-destination load
    out_sel = strobe(2); R_in = '0; R_in[2] = 1'b1; step();
    push("self_r2", RW'(32'd34));            pop_cmp(RW'(R_data[2*DATA_W +: DATA_W]));
    out_sel = strobe(SRC_MDR); MDR_data = 32'h55; R_in = '0; R_in[6] = 1'b1; R_in[7] = 1'b1;
    step();
    R_in = '0;
    push("multi_r6", RW'(32'h55));           pop_cmp(RW'(R_data[6*DATA_W +: DATA_W]));
    push("multi_r7", RW'(32'h55));           pop_cmp(RW'(R_data[7*DATA_W +: DATA_W]));

    // Reset mid-transfer wins over R4 -> R5
    out_sel = strobe(4); R_in = '0; R_in[5] = 1'b1; clr = 1'b0; step();
    clr = 1'b1; R_in = '0; #1;
    push("midrst_r4", '0);                   pop_cmp(RW'(R_data[4*DATA_W +: DATA_W]));
    push("midrst_r5", '0);                   pop_cmp(RW'(R_data[5*DATA_W +: DATA_W]));
    push("midrst_all", '0);                  pop_cmp(R_data);
    push("midrst_bus", '0);                  pop_cmp(RW'(BusMuxout));

    if (q_exp.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_leftover: observed %0d pending, required 0", q_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_mux.md
Name: bus_mux

Overview:
- Central 32-bit datapath bus of the CPU: 24 sources, 16 general-purpose registers (R0–R15) and 8 external datapath sources, selected by one-hot "out" strobes.
- Contains the R0–R15 register bank; each register loads from the bus under its own "in" enable.
- Register-to-register transfer over the bus completes in one clock edge (source out + destination in asserted in the same cycle).

Parameters:
- DATA_W, 32, width of bus and every source/register.
- NUM_GPR, 16, number of general-purpose registers inside the block (fixed source indices 0..NUM_GPR-1).

Ports:
- Clock  in  1  rising-edge clock.
- clr  in  1  synchronous active-low reset (sampled on rising Clock edge; 0 = reset).
- R_in  in  NUM_GPR  per-register load enable; bit i loads Ri from bus.
- HI_data, LO_data, Zhigh_data, Zlow_data, PC_data, MDR_data, InPort_data, C_sign_data  in  DATA_W each  external sources 16..23 in that order.
- out_sel  in  24  one-hot source strobes; bit k drives source k (0..15 = R0..R15, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 InPort, 23 C_sign).
- BusMuxout  out  DATA_W  current bus value (combinational).
- R_data  out  NUM_GPR*DATA_W  flattened register contents, Ri at bits [i*DATA_W +: DATA_W].
- sel_code  out  5  encoded index of driving source (31 when none).

Behaviour:
- Encoder: out_sel -> sel_code; lowest asserted index wins; no bit set -> sel_code = 31.
- Mux: BusMuxout = source[sel_code]; sel_code = 31 -> BusMuxout = 0. Purely combinational, zero-cycle latency from out_sel/source change.
- Registers: on rising Clock, if clr = 0 all Ri <= 0; else for each i with R_in[i] = 1, Ri <= BusMuxout (value before the edge). R_in[i] = 0 holds.
- Reset dominates R_in. Reset value: all Ri = 0, so R_data = 0 and BusMuxout = 0 when only GPR strobes are asserted.
- Self-load (out_sel[i] and R_in[i] both set) holds value; several R_in bits set load the same bus value into all of them.
- Multiple out_sel bits: lowest index drives; no X, no bus contention.
- No internal state other than R0–R15; no handshake.

Optional Feature:
- Macro BUS_MUX_SEL_ERR_EN.
- Defined: adds output sel_err (1 bit, combinational) = 1 when more than one out_sel bit is set; plus a simulation-only assertion message on each rising edge where sel_err = 1 and clr = 1.
- Undefined: no sel_err port, no check; mux behaviour identical.

Decomposition:
- Shared package: DATA_W, NUM_GPR, source index constants (SRC_R0..SRC_R15, SRC_HI=16, SRC_LO=17, SRC_ZHIGH=18, SRC_ZLOW=19, SRC_PC=20, SRC_MDR=21, SRC_INPORT=22, SRC_CSIGN=23, SRC_NONE=31), bus word typedef.
- One sub-module: bus_reg (DATA_W-bit register, Clock, synchronous active-low clr, enable, d, q), instantiated NUM_GPR times. Encoder and mux stay inline.

Test Plan:
- Reset: clr = 0 for 2 edges with R_in = all ones, MDR_data = 0xDEADBEEF, out_sel[21] = 1 -> all R_data = 0; BusMuxout = 0xDEADBEEF combinationally.
- External load: MDR_data = 34, out_sel[21], R_in[2] = 1, one edge -> R2 = 34, others 0; sel_code = 21.
- Chain transfer: out_sel[2] + R_in[4] one edge -> R4 = 34; then out_sel[4] + R_in[5] one edge -> R5 = 34; then out_sel[5] only -> BusMuxout = 34, sel_code = 5.
- Priority/none: R3 = 7, R9 = 9; out_sel bits 3 and 9 set -> BusMuxout = 7, sel_code = 3 (sel_err = 1 with BUS_MUX_SEL_ERR_EN); out_sel = 0 -> BusMuxout = 0, sel_code = 31.
- All external sources: drive distinct values 0x100+k on sources 16..23, strobe each in turn -> BusMuxout equals matching value, sel_code = k.
- Reset mid-operation: R4 = 34, clr = 0 with out_sel[4] + R_in[5] on same edge -> R4 = 0, R5 = 0 after edge.
